// File: rtl/serial_addr_sequencer_pkg.sv
// Shared types and constants for the serial readout/config port.
package serial_addr_sequencer_pkg;
    typedef enum logic [1:0] {IDLE, CMD, DATA, ERR} seq_state_t;

    localparam int RW_BIT   = 7;
    localparam int MAX_ADDR = 65;
    localparam int CH_BASE  = 4;
    localparam int CH_SPAN  = 7;
    localparam int NUM_CH   = 8;
endpackage

// File: rtl/serial_addr_sequencer_shift_in.sv
// MSB-first serial byte assembler: keeps the 7 previous bits, the byte completes with the current bit.
module serial_addr_sequencer_shift_in (
    input  logic       sclk,
    input  logic       rstn,
    input  logic       i_clr,
    input  logic       i_en,
    input  logic       i_d,
    output logic [7:0] o_byte
);
    logic [6:0] r_sr;

    always_ff @(posedge sclk) begin
        if (!rstn || i_clr)
            r_sr <= '0;
        else if (i_en)
            r_sr <= {r_sr[5:0], i_d};
    end

    assign o_byte = {r_sr, i_d};
endmodule

// File: rtl/serial_addr_sequencer.sv
// Serial port front end: decodes the command byte, steps the byte address and captures write bytes.
module serial_addr_sequencer
    import serial_addr_sequencer_pkg::*;
#(
    parameter int ADDR_W   = 8,
    parameter int MAX_ADDR = serial_addr_sequencer_pkg::MAX_ADDR,
    parameter int DATA_W   = 8
) (
    input  logic              sclk,
    input  logic              rstn,
    input  logic              csb,
    input  logic              sdi,
    output logic [ADDR_W-1:0] mux_ctrl,
    output logic              addr_valid,
    output logic              rd_mode,
    output logic [2:0]        bit_idx,
    output logic              byte_load,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              cmd_err
);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(MAX_ADDR);

    seq_state_t        r_state;
    logic [2:0]        r_cnt;
    logic [ADDR_W-1:0] r_mux;
    logic              r_valid;
    logic              r_rd;
    logic [2:0]        r_bit_idx;
    logic              r_byte_load;
    logic              r_wr_en;
    logic [ADDR_W-1:0] r_wr_addr;
    logic [DATA_W-1:0] r_wr_data;
    logic              r_err;

    logic [7:0]        w_cmd_byte;
    logic [7:0]        w_wr_byte;
    logic [ADDR_W-1:0] w_cmd_addr;
    logic [ADDR_W-1:0] w_mux_next;

    serial_addr_sequencer_shift_in u_cmd_sr (
        .sclk   (sclk),
        .rstn   (rstn),
        .i_clr  (csb),
        .i_en   (!csb && (r_state == IDLE || r_state == CMD)),
        .i_d    (sdi),
        .o_byte (w_cmd_byte)
    );

    serial_addr_sequencer_shift_in u_wr_sr (
        .sclk   (sclk),
        .rstn   (rstn),
        .i_clr  (csb),
        .i_en   (!csb && r_state == DATA && !r_rd),
        .i_d    (sdi),
        .o_byte (w_wr_byte)
    );

    assign w_cmd_addr = ADDR_W'(w_cmd_byte[6:0]);
    assign w_mux_next = (r_mux == LAST_ADDR) ? '0 : r_mux + ADDR_W'(1);

    always_ff @(posedge sclk) begin
        if (!rstn) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_mux       <= '0;
            r_valid     <= 1'b0;
            r_rd        <= 1'b0;
            r_bit_idx   <= 3'd7;
            r_byte_load <= 1'b0;
            r_wr_en     <= 1'b0;
            r_wr_addr   <= '0;
            r_wr_data   <= '0;
            r_err       <= 1'b0;
        end else begin
            r_byte_load <= 1'b0;
            r_wr_en     <= 1'b0;
            // Frame end wins over everything; mux_ctrl and the last write stay visible.
            if (csb) begin
                r_state   <= IDLE;
                r_valid   <= 1'b0;
                r_err     <= 1'b0;
                r_bit_idx <= 3'd7;
            end else begin
                case (r_state)
                    IDLE: begin
                        r_state <= CMD;
                        r_cnt   <= 3'd1;
                    end
                    CMD: begin
                        if (r_cnt == 3'd7) begin
                            r_mux     <= w_cmd_addr;
                            r_bit_idx <= 3'd7;
                            if (w_cmd_addr <= LAST_ADDR) begin
                                r_state     <= DATA;
                                r_valid     <= 1'b1;
                                r_rd        <= w_cmd_byte[RW_BIT];
                                r_byte_load <= w_cmd_byte[RW_BIT];
                            end else begin
                                r_state <= ERR;
                                r_err   <= 1'b1;
                            end
                        end else begin
                            r_cnt <= r_cnt + 3'd1;
                        end
                    end
                    DATA: begin
                        if (r_bit_idx == 3'd0) begin
                            r_mux       <= w_mux_next;
                            r_bit_idx   <= 3'd7;
                            r_byte_load <= r_rd;
                            if (!r_rd) begin
                                r_wr_en   <= 1'b1;
                                r_wr_addr <= r_mux;
                                r_wr_data <= DATA_W'(w_wr_byte);
                            end
                        end else begin
                            r_bit_idx <= r_bit_idx - 3'd1;
                        end
                    end
                    ERR: ;
                    default: r_state <= IDLE;
                endcase
            end
        end
    end

    assign mux_ctrl   = r_mux;
    assign addr_valid = r_valid;
    assign rd_mode    = r_rd;
    assign bit_idx    = r_bit_idx;
    assign byte_load  = r_byte_load;
    assign wr_en      = r_wr_en;
    assign wr_addr    = r_wr_addr;
    assign wr_data    = r_wr_data;
    assign cmd_err    = r_err;
endmodule

// File: tb/tb_serial_addr_sequencer.sv
// Randomized and directed bench for serial_addr_sequencer against a frame-level reference model.
module tb_serial_addr_sequencer;
    localparam int MAXA = 65;

    logic       sclk = 1'b0;
    logic       rstn = 1'b0;
    logic       csb  = 1'b1;
    logic       sdi  = 1'b0;
    logic [7:0] mux_ctrl;
    logic       addr_valid;
    logic       rd_mode;
    logic [2:0] bit_idx;
    logic       byte_load;
    logic       wr_en;
    logic [7:0] wr_addr;
    logic [7:0] wr_data;
    logic       cmd_err;

    int n_checks = 0;
    int n_errors = 0;

    // Model state that persists across frames
    int   m_mux = 0, m_wra = 0, m_wrd = 0;
    logic m_rd = 1'b0;
    bit   m_rd_known = 1'b1;
    int   n_bl, n_we;
    logic [7:0] data_q[$];

    serial_addr_sequencer dut (
        .sclk       (sclk),
        .rstn       (rstn),
        .csb        (csb),
        .sdi        (sdi),
        .mux_ctrl   (mux_ctrl),
        .addr_valid (addr_valid),
        .rd_mode    (rd_mode),
        .bit_idx    (bit_idx),
        .byte_load  (byte_load),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .cmd_err    (cmd_err)
    );

    always #5 sclk = ~sclk;

    task automatic step(input logic c, input logic d);
        @(negedge sclk);
        csb = c;
        sdi = d;
        @(posedge sclk);
        #1;
    endtask

    function automatic logic [36:0] observed();
        return {addr_valid, cmd_err, byte_load, wr_en, bit_idx, mux_ctrl, wr_addr, wr_data};
    endfunction

    // Drives one frame (command + nbits data bits from data_q), then one csb-high cycle.
    task automatic run_frame(input logic [7:0] cmd, input int nbits, input string name);
        int   addr, j;
        logic rd, legal, ev, err, bl, we, bitv;
        int   bi, mux;
        logic [36:0] exp_v;
        addr  = int'(cmd[6:0]);
        rd    = cmd[7];
        legal = (addr <= MAXA);
        n_bl  = 0;
        n_we  = 0;
        for (int e = 0; e < 8 + nbits; e++) begin
            if (e < 8) bitv = cmd[7-e];
            else       bitv = data_q[(e-8)/8][7-((e-8)%8)];
            step(1'b0, bitv);
            ev = 0; err = 0; bl = 0; we = 0; bi = 7; mux = m_mux;
            if (e >= 7 && !legal) begin
                err = 1; mux = addr; m_mux = addr; m_rd_known = 0;
            end else if (e >= 7) begin
                j   = e - 7;
                ev  = 1;
                mux = (addr + j/8) % (MAXA + 1);
                bi  = 7 - (j % 8);
                bl  = rd && (j % 8 == 0);
                we  = !rd && j > 0 && (j % 8 == 0);
                if (we) begin
                    m_wra = (addr + j/8 - 1) % (MAXA + 1);
                    m_wrd = int'(data_q[j/8 - 1]);
                end
                m_rd = rd; m_rd_known = 1; m_mux = mux;
            end
            exp_v = {ev, err, bl, we, 3'(bi), 8'(mux), 8'(m_wra), 8'(m_wrd)};
            n_bl += int'(byte_load);
            n_we += int'(wr_en);
            n_checks++;
            if (observed() !== exp_v) begin
                n_errors++;
                $display("FAIL %s edge %0d: {valid,err,bl,we,bit,mux,wa,wd} got %h exp %h", name, e, observed(), exp_v);
            end
            if (m_rd_known && e >= 7) begin
                n_checks++;
                if (rd_mode !== m_rd) begin
                    n_errors++;
                    $display("FAIL %s rd_mode edge %0d: got %b exp %b", name, e, rd_mode, m_rd);
                end
            end
        end
        step(1'b1, 1'b0);
        exp_v = {1'b0, 1'b0, 1'b0, 1'b0, 3'd7, 8'(m_mux), 8'(m_wra), 8'(m_wrd)};
        n_checks++;
        if (observed() !== exp_v) begin
            n_errors++;
            $display("FAIL %s csb-high: got %h exp %h", name, observed(), exp_v);
        end
    endtask

    task automatic reset_model();
        m_mux = 0; m_wra = 0; m_wrd = 0; m_rd = 0; m_rd_known = 1;
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        step(1'b0, 1'b1);
        n_checks++;
        if (observed() !== {4'b0, 3'd7, 24'd0} || rd_mode !== 1'b0) begin
            n_errors++;
            $display("FAIL reset: got %h rd %b exp %h", observed(), rd_mode, {4'b0, 3'd7, 24'd0});
        end
        rstn = 1'b1;
        step(1'b1, 1'b0);
        reset_model();
    endtask

    task automatic test_read();
        data_q = {8'h00, 8'h00};
        run_frame(8'h84, 16, "read");
        n_checks++;
        if (n_bl != 3 || n_we != 0) begin
            n_errors++;
            $display("FAIL read_strobes: byte_load %0d wr_en %0d exp 3 0", n_bl, n_we);
        end
    endtask

    task automatic test_wrap();
        data_q = {8'hFF, 8'hFF};
        run_frame(8'hC0, 16, "wrap");
        n_checks++;
        if (mux_ctrl !== 8'd0) begin
            n_errors++;
            $display("FAIL wrap_final: mux_ctrl %0d exp 0", mux_ctrl);
        end
    endtask

    task automatic test_write();
        data_q = {8'hA5};
        run_frame(8'h02, 8, "write");
        n_checks++;
        if (n_we != 1 || n_bl != 0 || wr_addr !== 8'd2 || wr_data !== 8'hA5) begin
            n_errors++;
            $display("FAIL write_result: we %0d bl %0d addr %0d data %h exp 1 0 2 a5", n_we, n_bl, wr_addr, wr_data);
        end
    endtask

    task automatic test_illegal();
        data_q = {8'h5A, 8'hC3};
        run_frame(8'hC6, 16, "illegal");
        n_checks++;
        if (n_we != 0 || n_bl != 0) begin
            n_errors++;
            $display("FAIL illegal_strobes: we %0d bl %0d exp 0 0", n_we, n_bl);
        end
        data_q = {8'h3C};
        run_frame(8'h83, 8, "after_illegal");
    endtask

    task automatic test_abort();
        data_q = {8'hB7};
        run_frame(8'h05, 4, "abort");
        n_checks++;
        if (n_we != 0) begin
            n_errors++;
            $display("FAIL abort_wr_en: got %0d pulses exp 0", n_we);
        end
        data_q = {8'h69};
        run_frame(8'h07, 8, "after_abort");
        n_checks++;
        if (n_we != 1 || wr_data !== 8'h69 || wr_addr !== 8'd7) begin
            n_errors++;
            $display("FAIL after_abort_write: we %0d addr %0d data %h exp 1 7 69", n_we, wr_addr, wr_data);
        end
    endtask

    task automatic test_reset_mid();
        for (int e = 0; e < 12; e++) step(1'b0, (e == 0 || e == 5) ? 1'b1 : 1'b0);
        rstn = 1'b0;
        step(1'b0, 1'b1);
        n_checks++;
        if (observed() !== {4'b0, 3'd7, 24'd0} || rd_mode !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_mid: got %h exp %h", observed(), {4'b0, 3'd7, 24'd0});
        end
        rstn = 1'b1;
        step(1'b1, 1'b1);
        n_checks++;
        if (observed() !== {4'b0, 3'd7, 24'd0}) begin
            n_errors++;
            $display("FAIL reset_release_idle: got %h exp %h", observed(), {4'b0, 3'd7, 24'd0});
        end
        reset_model();
        data_q = {8'h11, 8'h22};
        run_frame(8'h81, 16, "post_reset");
    endtask

    task automatic test_random();
        logic [7:0] cmd;
        int nb;
        for (int f = 0; f < 25; f++) begin
            cmd = {1'($urandom_range(1)), 7'($urandom_range(MAXA + 5))};
            if (f % 5 == 0) cmd[6:0] = 7'($urandom_range(MAXA, MAXA - 2));
            nb = $urandom_range(40);
            data_q = {};
            for (int b = 0; b < 6; b++) data_q.push_back(8'($urandom));
            run_frame(cmd, nb, "random");
        end
    endtask

    initial begin
        test_reset();
        test_read();
        test_wrap();
        test_write();
        test_illegal();
        test_abort();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
